lsu_sequencer: RTL and testbench
================================

# lsu_sequencer

- Load/store sequencer between the execute stage and the byte-addressed data memory.
- Accepts one RISC-V load/store per handshake, decoded by funct3: LB/LH/LW/LBU/LHU and SB/SH/SW.
- The memory only supports byte and word transfers. This block therefore splits halfword and misaligned word accesses into byte beats, drives the memory port beat by beat, reassembles read bytes, and sign- or zero-extends the result.
- Returns a one-cycle response pulse that the pipeline uses to release its stall.

## Interface
Parameters:
- ADDR_W, 12: memory byte-address width; all beat addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  high only in IDLE; request accepted on an edge where req_valid && req_ready.
- req_we  in  1  0 load, 1 store.
- req_funct3  in  3  RISC-V funct3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  illegal funct3, valid with resp_valid.
- resp_split  out  1  access was split into byte beats, valid with resp_valid.
- mem_addr  out  ADDR_W  beat address (registered).
- mem_re  out  1  beat read enable (registered).
- mem_we  out  1  beat write enable (registered).
- mem_ls  out  1  0 byte, 1 word (registered).
- mem_wdata  out  32  beat write data; byte beats in [7:0], upper bits 0.
- mem_rdata  in  32  memory read data, valid the cycle after the read request cycle.

## Operation
States:
- IDLE: req_ready=1; the response pulse is also issued here.
- XFER: one beat issued per cycle.
- DRAIN: loads only; captures the data of the last beat.
- ERR: one cycle, then the response.

Beat plan, latched at accept:
- Legal loads: funct3 0,1,2,4,5. Legal stores: funct3 0,1,2. Anything else goes to ERR; no mem_re/mem_we ever asserted.
- LB/LBU/SB: 1 byte beat at addr.
- LH/LHU/SH: 2 byte beats at addr, addr+1, at any alignment.
- LW/SW with addr[1:0]==0: 1 word beat, mem_ls=1.
- LW/SW with addr[1:0]!=0: 4 byte beats at addr+0..3; resp_split=1.
- resp_split=1 whenever the beat count is >1 or the access is a misaligned word.

Beat rules:
- Byte beat k: mem_addr = (addr+k) mod 2^ADDR_W; store byte = req_wdata[8k+7:8k].
- Load byte k: mem_rdata[7:0] goes into assembly byte k.

Load result extension:
- LB: sign from bit 7. LH: sign from bit 15.
- LBU/LHU: zero-extended. LW: unchanged.

Beat sequencing:
- Beats are issued in consecutive cycles with no gaps.
- mem_re/mem_we deassert in the cycle after the last beat.
- Request fields are latched at accept; later changes on req_* are ignored until the next accept.

Reset:
- Any cycle with reset_n low → IDLE next edge.
- All outputs go to 0, except req_ready=1.
- Beat counter and assembly register are cleared.
- An in-flight access is abandoned with no response; a write beat already presented is not retracted.

## Timing
Accept at edge E0; N = beat count.
- Beat k is presented on mem_* during the cycle after edge E(k).
- Store: resp_valid is high in the cycle after edge E(N); with N=1 it is high in the second cycle after accept.
- Load: the last data is captured at edge E(N+1); resp_valid is high in the cycle after E(N+1).
- Error: resp_valid and resp_err are high in the cycle after edge E1.
- Back-to-back: a new request may be accepted in the same cycle resp_valid is high (state is IDLE); its first beat follows the next edge.
- resp_rdata, resp_err and resp_split are valid only while resp_valid=1.
- Outside the resp_valid cycle, resp_rdata, resp_err and resp_split hold 0.

## Test plan
- Aligned LW at 0x100, memory bytes 11,22,33,44: one beat (mem_ls=1, addr 0x100); resp_rdata=0x44332211, resp_split=0, resp_valid in the cycle after E2.
- Misaligned LW at 0xFFE, bytes AA,BB,CC,DD at 0xFFE,0xFFF,0x000,0x001: beat addresses FFE,FFF,000,001 in consecutive cycles; resp_rdata=0xDDCCBBAA, resp_split=1, resp_valid in the cycle after E5.
- LH at 0x10 with bytes 80,FF: resp_rdata=0xFFFFFF80. LHU at the same address: resp_rdata=0x0000FF80. LB at 0x10: 0xFFFFFF80. LBU at 0x10: 0x00000080.
- SH at 0x21, wdata 0xDEADBEEF: byte writes 0xEF@0x21 then 0xBE@0x22; memory at 0x20 and 0x23 unchanged; resp_valid in the cycle after E2 with resp_rdata=0.
- Store with funct3=3'b011: no mem_we; resp_err=1, resp_valid in the cycle after E1. A legal LW accepted in that resp cycle completes normally.
- reset_n low during beat 2 of a misaligned LW: next cycle all mem_* and resp_* are 0, req_ready=1, no resp_valid; a subsequent LB returns correct data.

Source files
------------

// File: rtl/lsu_sequencer.sv
// -----------------------------------------------------------------------------
// lsu_sequencer
//
// Load/store sequencer between the execute stage and a byte-addressed data
// memory that only supports byte and word transfers. Halfword and misaligned
// word accesses are broken into consecutive byte beats. Read bytes are
// reassembled and the load result is sign- or zero-extended. Every accepted
// request ends with a one-cycle response pulse.
//
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_we, req_funct3       0 load / 1 store, RISC-V funct3
//   req_addr, req_wdata      byte address, store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata               extended load result (0 for stores / errors)
//   resp_err                 illegal funct3
//   resp_split               access was split into byte beats
//   mem_addr/re/we/ls/wdata  registered beat request (ls: 0 byte, 1 word)
//   mem_rdata                read data, valid the cycle after the read beat
// -----------------------------------------------------------------------------
module lsu_sequencer #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              resp_split,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic              mem_ls,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2,
      ERR   = 2'd3
   } state_t;

   // Legal encodings: loads LB/LH/LW/LBU/LHU, stores SB/SH/SW.
   function automatic logic is_legal(input logic we, input logic [2:0] f3);
      logic ok;
      case (f3)
         3'd0, 3'd1, 3'd2: ok = 1'b1;
         3'd4, 3'd5:       ok = ~we;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Final load result formatting from the assembled bytes.
   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] r;
      case (f3)
         3'd0:    r = {{24{a[7]}}, a[7:0]};
         3'd1:    r = {{16{a[15]}}, a[15:0]};
         3'd4:    r = {24'h000000, a[7:0]};
         3'd5:    r = {16'h0000, a[15:0]};
         default: r = a;
      endcase
      return r;
   endfunction

   // ---------------- registers ----------------
   state_t            state_r;
   logic [ADDR_W-1:0] base_r;
   logic              we_r;
   logic [2:0]        f3_r;
   logic [31:0]       wdata_r;
   logic [2:0]        nbeats_r;
   logic              word_r;
   logic              split_r;
   logic [2:0]        beat_r;      // index of the next beat to issue
   logic [31:0]       asm_r;       // read byte assembly
   logic              pend_r;      // read data for an earlier beat arrives now
   logic [1:0]        pend_idx_r;
   logic              pend_word_r;
   logic [1:0]        mem_idx_r;   // beat index of the beat currently on mem_*
   logic [ADDR_W-1:0] mem_addr_r;
   logic              mem_re_r;
   logic              mem_we_r;
   logic              mem_ls_r;
   logic [31:0]       mem_wdata_r;
   logic              resp_valid_r;
   logic [31:0]       resp_rdata_r;
   logic              resp_err_r;
   logic              resp_split_r;

   // ---------------- next-state signals ----------------
   state_t            state_s;
   logic [ADDR_W-1:0] base_s;
   logic              we_s;
   logic [2:0]        f3_s;
   logic [31:0]       wdata_s;
   logic [2:0]        nbeats_s;
   logic              word_s;
   logic              split_s;
   logic [2:0]        beat_s;
   logic [31:0]       asm_s;
   logic              pend_s;
   logic [1:0]        pend_idx_s;
   logic              pend_word_s;
   logic [1:0]        mem_idx_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic              mem_re_s;
   logic              mem_we_s;
   logic              mem_ls_s;
   logic [31:0]       mem_wdata_s;
   logic              resp_valid_s;
   logic [31:0]       resp_rdata_s;
   logic              resp_err_s;
   logic              resp_split_s;

   // Beat issue request and the access it belongs to (request or latched copy).
   logic              issue_s;
   logic [1:0]        iss_idx_s;
   logic [ADDR_W-1:0] iss_base_s;
   logic              iss_we_s;
   logic [31:0]       iss_wdata_s;
   logic              iss_word_s;

   assign req_ready  = (state_r == IDLE);
   assign resp_valid = resp_valid_r;
   assign resp_rdata = resp_rdata_r;
   assign resp_err   = resp_err_r;
   assign resp_split = resp_split_r;
   assign mem_addr   = mem_addr_r;
   assign mem_re     = mem_re_r;
   assign mem_we     = mem_we_r;
   assign mem_ls     = mem_ls_r;
   assign mem_wdata  = mem_wdata_r;

   // Next-state, beat issue, read capture and response generation.
   always_comb begin
      state_s      = state_r;
      base_s       = base_r;
      we_s         = we_r;
      f3_s         = f3_r;
      wdata_s      = wdata_r;
      nbeats_s     = nbeats_r;
      word_s       = word_r;
      split_s      = split_r;
      beat_s       = beat_r;
      resp_valid_s = 1'b0;
      resp_rdata_s = 32'h0000_0000;
      resp_err_s   = 1'b0;
      resp_split_s = 1'b0;
      issue_s      = 1'b0;
      iss_idx_s    = 2'd0;
      iss_base_s   = base_r;
      iss_we_s     = we_r;
      iss_wdata_s  = wdata_r;
      iss_word_s   = word_r;

      // A read beat presented last cycle has its data on mem_rdata now.
      asm_s = asm_r;
      if (pend_r) begin
         if (pend_word_r) begin
            asm_s = mem_rdata;
         end else begin
            asm_s[{pend_idx_r, 3'b000} +: 8] = mem_rdata[7:0];
         end
      end else begin
         asm_s = asm_r;
      end
      pend_s      = mem_re_r;
      pend_idx_s  = mem_idx_r;
      pend_word_s = mem_ls_r;

      case (state_r)
         IDLE: begin
            if (req_valid) begin
               base_s  = req_addr;
               we_s    = req_we;
               f3_s    = req_funct3;
               wdata_s = req_wdata;
               asm_s   = 32'h0000_0000;
               if (is_legal(req_we, req_funct3)) begin
                  word_s = (req_funct3[1:0] == 2'b10) && (req_addr[1:0] == 2'b00);
                  case (req_funct3[1:0])
                     2'b00:   nbeats_s = 3'd1;
                     2'b01:   nbeats_s = 3'd2;
                     2'b10:   nbeats_s = (req_addr[1:0] == 2'b00) ? 3'd1 : 3'd4;
                     default: nbeats_s = 3'd1;
                  endcase
                  // A misaligned word always has 4 beats, so this covers it.
                  split_s     = (nbeats_s > 3'd1);
                  issue_s     = 1'b1;
                  iss_idx_s   = 2'd0;
                  iss_base_s  = req_addr;
                  iss_we_s    = req_we;
                  iss_wdata_s = req_wdata;
                  iss_word_s  = word_s;
                  beat_s      = 3'd1;
                  state_s     = XFER;
               end else begin
                  word_s   = 1'b0;
                  nbeats_s = 3'd0;
                  split_s  = 1'b0;
                  beat_s   = 3'd0;
                  state_s  = ERR;
               end
            end else begin
               state_s = IDLE;
            end
         end
         XFER: begin
            if (beat_r < nbeats_r) begin
               issue_s   = 1'b1;
               iss_idx_s = beat_r[1:0];
               beat_s    = beat_r + 3'd1;
            end else if (we_r) begin
               resp_valid_s = 1'b1;
               resp_split_s = split_r;
               state_s      = IDLE;
            end else begin
               // Last read beat's data is still one cycle away.
               state_s = DRAIN;
            end
         end
         DRAIN: begin
            resp_valid_s = 1'b1;
            resp_rdata_s = extend(f3_r, asm_s);
            resp_split_s = split_r;
            state_s      = IDLE;
         end
         ERR: begin
            resp_valid_s = 1'b1;
            resp_err_s   = 1'b1;
            state_s      = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      // Beat formatting; mem_* fall to 0 in any cycle without a beat.
      if (issue_s) begin
         mem_idx_s   = iss_idx_s;
         mem_addr_s  = iss_base_s + ADDR_W'(iss_idx_s);
         mem_re_s    = ~iss_we_s;
         mem_we_s    = iss_we_s;
         mem_ls_s    = iss_word_s;
         mem_wdata_s = iss_word_s ? iss_wdata_s
                                  : {24'h000000, iss_wdata_s[{iss_idx_s, 3'b000} +: 8]};
      end else begin
         mem_idx_s   = 2'd0;
         mem_addr_s  = '0;
         mem_re_s    = 1'b0;
         mem_we_s    = 1'b0;
         mem_ls_s    = 1'b0;
         mem_wdata_s = 32'h0000_0000;
      end
   end

   // State and registered outputs; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         base_r       <= '0;
         we_r         <= 1'b0;
         f3_r         <= 3'd0;
         wdata_r      <= 32'h0000_0000;
         nbeats_r     <= 3'd0;
         word_r       <= 1'b0;
         split_r      <= 1'b0;
         beat_r       <= 3'd0;
         asm_r        <= 32'h0000_0000;
         pend_r       <= 1'b0;
         pend_idx_r   <= 2'd0;
         pend_word_r  <= 1'b0;
         mem_idx_r    <= 2'd0;
         mem_addr_r   <= '0;
         mem_re_r     <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_ls_r     <= 1'b0;
         mem_wdata_r  <= 32'h0000_0000;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
         resp_err_r   <= 1'b0;
         resp_split_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         base_r       <= base_s;
         we_r         <= we_s;
         f3_r         <= f3_s;
         wdata_r      <= wdata_s;
         nbeats_r     <= nbeats_s;
         word_r       <= word_s;
         split_r      <= split_s;
         beat_r       <= beat_s;
         asm_r        <= asm_s;
         pend_r       <= pend_s;
         pend_idx_r   <= pend_idx_s;
         pend_word_r  <= pend_word_s;
         mem_idx_r    <= mem_idx_s;
         mem_addr_r   <= mem_addr_s;
         mem_re_r     <= mem_re_s;
         mem_we_r     <= mem_we_s;
         mem_ls_r     <= mem_ls_s;
         mem_wdata_r  <= mem_wdata_s;
         resp_valid_r <= resp_valid_s;
         resp_rdata_r <= resp_rdata_s;
         resp_err_r   <= resp_err_s;
         resp_split_r <= resp_split_s;
      end
   end

endmodule

// File: tb/tb_lsu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lsu_sequencer: table-driven directed bench with a byte memory model.
// -----------------------------------------------------------------------------
module tb_lsu_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        resp_split;
   logic [11:0] mem_addr;
   logic        mem_re;
   logic        mem_we;
   logic        mem_ls;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   lsu_sequencer #(.ADDR_W(12)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .resp_split(resp_split), .mem_addr(mem_addr), .mem_re(mem_re),
      .mem_we(mem_we), .mem_ls(mem_ls), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   logic [7:0] mem [4096];
   bit         mem_init = 1'b0;

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
         mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
         mem[12'hFFE] = 8'hAA; mem[12'hFFF] = 8'hBB; mem[12'h000] = 8'hCC; mem[12'h001] = 8'hDD;
         mem[12'h010] = 8'h80; mem[12'h011] = 8'hFF;
         mem[12'h020] = 8'h01; mem[12'h021] = 8'h02; mem[12'h022] = 8'h03; mem[12'h023] = 8'h04;
         mem_init = 1'b1;
      end
      if (mem_we === 1'b1) begin
         if (mem_ls) begin
            mem[mem_addr]         = mem_wdata[7:0];
            mem[mem_addr + 12'd1] = mem_wdata[15:8];
            mem[mem_addr + 12'd2] = mem_wdata[23:16];
            mem[mem_addr + 12'd3] = mem_wdata[31:24];
         end else begin
            mem[mem_addr] = mem_wdata[7:0];
         end
      end
      // Byte reads also return neighbouring bytes above [7:0]; junk when idle.
      if (mem_re === 1'b1)
         mem_rdata <= {mem[mem_addr + 12'd3], mem[mem_addr + 12'd2],
                       mem[mem_addr + 12'd1], mem[mem_addr]};
      else
         mem_rdata <= 32'h5A5A_5A5A;
   end

   // ---------------- beat log ----------------
   int          cyc = 0;
   int          log_n = 0;
   logic [11:0] log_addr [256];
   logic        log_we   [256];
   logic        log_ls   [256];
   logic [31:0] log_wd   [256];
   int          log_cyc  [256];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_re === 1'b1 || mem_we === 1'b1) begin
         if (log_n < 256) begin
            log_addr[log_n] = mem_addr;
            log_we[log_n]   = mem_we;
            log_ls[log_n]   = mem_ls;
            log_wd[log_n]   = mem_wdata;
            log_cyc[log_n]  = cyc;
         end
         log_n = log_n + 1;
      end
   end

   // ---------------- checking ----------------
   int n_chk  = 0;
   int n_fail = 0;
   int idle_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Counts edges after the accept edge until resp_valid is seen (-1 on timeout).
   task automatic wait_resp(output logic [31:0] rd, output logic er, output logic sp, output int lat);
      bit found = 1'b0;
      rd = 32'h0; er = 1'b0; sp = 1'b0; lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (resp_valid === 1'b1) begin
            rd = resp_rdata; er = resp_err; sp = resp_split;
            found = 1'b1;
            break;
         end else if (resp_rdata !== 32'h0 || resp_err !== 1'b0 || resp_split !== 1'b0) begin
            idle_bad++;
         end
      end
      if (!found) lat = -1;
   endtask

   task automatic drive_req(input logic we, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      // Garbage after accept must be ignored.
      req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111; req_addr = ~a; req_wdata = 32'h0BAD_0BAD;
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output logic sp, output int lat);
      @(negedge clk);
      drive_req(we, f3, a, wd);
      wait_resp(rd, er, sp, lat);
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_split;
      int          exp_lat;
      int          exp_beats;
   } vec_t;

   vec_t vecs [20];

   initial begin
      logic [31:0] rd;
      logic        er, sp;
      int          lat, base, nwe, seen;

      vecs[0]  = '{1'b0, 3'd2, 12'h100, 32'h0, 32'h4433_2211, 1'b0, 1'b0, 2, 1};
      vecs[1]  = '{1'b0, 3'd2, 12'hFFE, 32'h0, 32'hDDCC_BBAA, 1'b0, 1'b1, 5, 4};
      vecs[2]  = '{1'b0, 3'd1, 12'h010, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b1, 3, 2};
      vecs[3]  = '{1'b0, 3'd5, 12'h010, 32'h0, 32'h0000_FF80, 1'b0, 1'b1, 3, 2};
      vecs[4]  = '{1'b0, 3'd0, 12'h010, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0, 2, 1};
      vecs[5]  = '{1'b0, 3'd4, 12'h010, 32'h0, 32'h0000_0080, 1'b0, 1'b0, 2, 1};
      vecs[6]  = '{1'b1, 3'd1, 12'h021, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 2, 2};
      vecs[7]  = '{1'b0, 3'd2, 12'h020, 32'h0, 32'h04BE_EF01, 1'b0, 1'b0, 2, 1};
      vecs[8]  = '{1'b1, 3'd2, 12'h031, 32'h1122_3344, 32'h0, 1'b0, 1'b1, 4, 4};
      vecs[9]  = '{1'b0, 3'd2, 12'h031, 32'h0, 32'h1122_3344, 1'b0, 1'b1, 5, 4};
      vecs[10] = '{1'b1, 3'd0, 12'h040, 32'h1234_56A5, 32'h0, 1'b0, 1'b0, 1, 1};
      vecs[11] = '{1'b0, 3'd0, 12'h040, 32'h0, 32'hFFFF_FFA5, 1'b0, 1'b0, 2, 1};
      vecs[12] = '{1'b1, 3'd2, 12'h050, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 1, 1};
      vecs[13] = '{1'b0, 3'd2, 12'h050, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 2, 1};
      vecs[14] = '{1'b0, 3'd3, 12'h100, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0};
      vecs[15] = '{1'b0, 3'd6, 12'h100, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0};
      vecs[16] = '{1'b1, 3'd4, 12'h060, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1, 0};
      vecs[17] = '{1'b0, 3'd1, 12'h033, 32'h0, 32'h0000_1122, 1'b0, 1'b1, 3, 2};
      vecs[18] = '{1'b0, 3'd5, 12'hFFF, 32'h0, 32'h0000_CCBB, 1'b0, 1'b1, 3, 2};
      vecs[19] = '{1'b0, 3'd1, 12'hFFF, 32'h0, 32'hFFFF_CCBB, 1'b0, 1'b1, 3, 2};

      reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 12'h0; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_ctl", {26'h0, mem_re, mem_we, mem_ls, resp_valid, resp_err, resp_split}, 32'h0);
      chk("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      reset_n = 1'b1;

      // ---------------- table ----------------
      for (int i = 0; i < 20; i++) begin
         base = log_n;
         do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, sp, lat);
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
         chk($sformatf("v%0d_split", i), {31'h0, sp}, {31'h0, vecs[i].exp_split});
         chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
         chk($sformatf("v%0d_beats", i), log_n - base, vecs[i].exp_beats);
         chk($sformatf("v%0d_ready", i), {31'h0, req_ready}, 32'h1);
         if (i == 0) begin
            chk("lw_al_addr", {20'h0, log_addr[base]}, 32'h100);
            chk("lw_al_ls", {31'h0, log_ls[base]}, 32'h1);
         end
         if (i == 1) begin
            chk("lw_mis_a0", {20'h0, log_addr[base]},     32'hFFE);
            chk("lw_mis_a1", {20'h0, log_addr[base + 1]}, 32'hFFF);
            chk("lw_mis_a2", {20'h0, log_addr[base + 2]}, 32'h000);
            chk("lw_mis_a3", {20'h0, log_addr[base + 3]}, 32'h001);
            chk("lw_mis_gap", log_cyc[base + 3] - log_cyc[base], 3);
            chk("lw_mis_ls", {31'h0, log_ls[base + 2]}, 32'h0);
         end
         if (i == 6) begin
            chk("sh_a0", {20'h0, log_addr[base]}, 32'h021);
            chk("sh_d0", log_wd[base], 32'h0000_00EF);
            chk("sh_a1", {20'h0, log_addr[base + 1]}, 32'h022);
            chk("sh_d1", log_wd[base + 1], 32'h0000_00BE);
            chk("sh_we", {30'h0, log_we[base], log_we[base + 1]}, 32'h3);
         end
      end
      chk("resp_idle_zero", idle_bad, 0);

      // ---------------- illegal store then back-to-back LW ----------------
      base = log_n;
      @(negedge clk);
      drive_req(1'b1, 3'b011, 12'h070, 32'h1111_1111);
      @(negedge clk);
      chk("err_resp_early", {31'h0, resp_valid}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("err_resp", {29'h0, resp_valid, resp_err, req_ready}, 32'h7);
      chk("err_rdata", resp_rdata, 32'h0);
      drive_req(1'b0, 3'd2, 12'h100, 32'h0);
      wait_resp(rd, er, sp, lat);
      chk("b2b_rdata", rd, 32'h4433_2211);
      chk("b2b_err", {31'h0, er}, 32'h0);
      chk("b2b_lat", lat, 2);
      nwe = 0;
      for (int k = base; k < log_n; k++) if (log_we[k]) nwe++;
      chk("err_no_we", nwe, 0);
      chk("b2b_beats", log_n - base, 1);

      // ---------------- reset during beat 2 of a misaligned LW ----------------
      @(negedge clk);
      drive_req(1'b0, 3'd2, 12'hFFE, 32'h0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rstmid_beat2", {20'h0, mem_addr}, 32'h000);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      chk("rstmid_ctl", {26'h0, mem_re, mem_we, mem_ls, resp_valid, resp_err, resp_split}, 32'h0);
      chk("rstmid_addr", {20'h0, mem_addr}, 32'h0);
      chk("rstmid_wdata", mem_wdata, 32'h0);
      chk("rstmid_rdata", resp_rdata, 32'h0);
      chk("rstmid_ready", {31'h0, req_ready}, 32'h1);
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) seen++;
      end
      chk("rstmid_no_resp", seen, 0);
      do_req(1'b0, 3'd0, 12'h010, 32'h0, rd, er, sp, lat);
      chk("rstmid_lb_rdata", rd, 32'hFFFF_FF80);
      chk("rstmid_lb_lat", lat, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
